pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum number of consecutive dmem_busy cycles before a timeout is flagged.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rs1_addr_id, rs2_addr_id  input  5 each  ID-stage source register addresses.
REQ-006 rs1_used_id, rs2_used_id  input  1 each  the ID instruction reads that source register.
REQ-007 rd_addr_ex, rd_addr_mem, rd_addr_wb  input  5 each  destination register addresses at the EX, MEM and WB stages.
REQ-008 reg_write_ex, reg_write_mem, reg_write_wb  input  1 each  the instruction at that stage writes the register file.
REQ-009 mem_read_ex  input  1  the EX instruction is a load.
REQ-010 branch_taken_ex  input  1  the EX-stage branch or jump redirects the PC.
REQ-011 dmem_busy  input  1  the data memory has not completed its access.
REQ-012 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  output  1 each  hold the named register.
REQ-013 id_ex_bubble, if_id_flush  output  1 each  load a NOP into the named register.
REQ-014 fwd_sel_rs1, fwd_sel_rs2  output  2 each  operand source: 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
REQ-015 state  output  2  current FSM state.
REQ-016 mem_timeout  output  1  sticky error flag.

Function
REQ-017 The FSM SHALL have the states RUN=00, LOAD_STALL=01, MEM_WAIT=10 and FLUSH=11; transitions SHALL occur on the rising edge of clk.
REQ-018 A hazard match SHALL be: the source register is used, the producing stage has reg_write set, the destination is non-zero, and the destination equals the source address.
REQ-019 Forwarding SHALL be combinational: a match with the MEM stage selects 01; otherwise a match with the WB stage selects 10; otherwise 00. MEM SHALL win when both stages match.
REQ-020 A load-use hazard SHALL be: mem_read_ex set and an EX-stage match on any used source.
REQ-021 Priority each cycle SHALL be: dmem_busy, then branch_taken_ex, then load-use.
REQ-022 In any state, dmem_busy high SHALL combinationally assert all four stall outputs, with no bubble and no flush, and SHALL move the FSM to MEM_WAIT.
REQ-023 MEM_WAIT SHALL remain while dmem_busy is high and SHALL return to RUN in the cycle after dmem_busy falls.
REQ-024 In RUN or LOAD_STALL, branch_taken_ex SHALL assert if_id_flush and id_ex_bubble in the same cycle, and the FSM SHALL then enter FLUSH.
REQ-025 In FLUSH, load-use detection and flush SHALL be suppressed for exactly one cycle, and the FSM SHALL then return to RUN.
REQ-026 In RUN, a load-use hazard SHALL assert pc_stall, if_id_stall and id_ex_bubble in the same cycle, and the FSM SHALL then enter LOAD_STALL.
REQ-027 LOAD_STALL SHALL last exactly one cycle, with its outputs derived as in RUN, and a repeated load-use hazard SHALL be stalled again.
REQ-028 A wait counter SHALL increment each cycle in MEM_WAIT and clear on exit.
REQ-029 On reaching TIMEOUT_CYC, mem_timeout SHALL be set and SHALL stay set until reset; the stalls SHALL continue.
REQ-030 x0 SHALL never cause forwarding or a stall.

Reset
REQ-031 Asserting reset SHALL asynchronously force state=RUN, clear the wait counter, clear mem_timeout and clear the perf counters.
REQ-032 While reset is asserted, every stall, bubble and flush output SHALL be 0 regardless of the inputs.
REQ-033 A reset asserted mid-MEM_WAIT or mid-LOAD_STALL SHALL abandon that operation with no residual stall.

Configuration
REQ-034 With HAZARD_PERF_CNT_EN defined, the block SHALL add the outputs stall_cnt, flush_cnt and memwait_cnt, each CNT_W wide.
REQ-035 stall_cnt SHALL count load-use stall cycles, flush_cnt SHALL count branch flushes, and memwait_cnt SHALL count MEM_WAIT cycles; all three SHALL saturate at all-ones.
REQ-036 Without HAZARD_PERF_CNT_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 A shared package SHALL hold the state encoding, the forward-select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB) and the default for TIMEOUT_CYC.
REQ-038 Forward selection SHALL live in one sub-module, forward_select_unit, instantiated once per source register.

Verification
REQ-039 Bench SHALL drive rd_addr_mem=5, reg_write_mem=1, rd_addr_wb=5, reg_write_wb=1, rs1_addr_id=5, rs1_used_id=1 -> fwd_sel_rs1=01; then drop reg_write_mem -> 10.
REQ-040 Bench SHALL drive mem_read_ex=1, rd_addr_ex=7, reg_write_ex=1, rs2_addr_id=7, rs2_used_id=1 -> pc_stall, if_id_stall and id_ex_bubble=1 for one cycle, state RUN->LOAD_STALL->RUN; then the same with rd=0 -> no stall.
REQ-041 Bench SHALL drive branch_taken_ex=1 together with a load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_stall=0, then FLUSH for one cycle, then RUN.
REQ-042 Bench SHALL hold dmem_busy for 3 cycles during a branch -> all stalls=1 with no flush for 3 cycles; the flush SHALL occur in the cycle after dmem_busy falls.
REQ-043 Bench SHALL use TIMEOUT_CYC=4 and hold dmem_busy for 6 cycles -> mem_timeout rises after 4 MEM_WAIT cycles and stays set; reset clears it.
REQ-044 Bench SHALL assert reset during MEM_WAIT -> all outputs 0 and state=RUN immediately; with HAZARD_PERF_CNT_EN, the counters SHALL read 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// operand forward-select encodings, parameter defaults and the common
// register-hazard match function.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MEM_WAIT   = 2'b10,
        ST_FLUSH      = 2'b11
    } state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;  // operand from the register file
    localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from the EX/MEM register
    localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from the MEM/WB register

    localparam int TIMEOUT_CYC_DEFAULT = 64;
    localparam int CNT_W_DEFAULT       = 16;

    // A producer hazards a consumer only if the source is really read, the
    // producer really writes, and the register is not x0 (hard-wired zero).
    function automatic logic hazard_match(
        input logic       src_used,
        input logic [4:0] src_addr,
        input logic       dst_we,
        input logic [4:0] dst_addr
    );
        return src_used && dst_we && (dst_addr != 5'd0) && (dst_addr == src_addr);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_forward_select_unit.sv
// Operand forward selection for one ID-stage source register. The MEM-stage
// result is younger than the WB-stage result, so it wins when both match.
module forward_select_unit
    import pipeline_hazard_controller_pkg::*;
(
    input  logic       src_used,
    input  logic [4:0] src_addr,
    input  logic       reg_write_mem,
    input  logic [4:0] rd_addr_mem,
    input  logic       reg_write_wb,
    input  logic [4:0] rd_addr_wb,
    output logic [1:0] fwd_sel
);

    // Priority select: MEM match, then WB match, else register file.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        fwd_sel = FWD_RF;
        if (hazard_match(src_used, src_addr, reg_write_mem, rd_addr_mem)) begin
            fwd_sel = FWD_EXMEM;
        end else if (hazard_match(src_used, src_addr, reg_write_wb, rd_addr_wb)) begin
            fwd_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, branch
// flushes and data-memory wait stalls with a sticky timeout flag.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating performance
// counters (stall_cnt, flush_cnt, memwait_cnt).
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_addr_id,
    input  logic [4:0] rs2_addr_id,
    input  logic       rs1_used_id,
    input  logic       rs2_used_id,
    input  logic [4:0] rd_addr_ex,
    input  logic [4:0] rd_addr_mem,
    input  logic [4:0] rd_addr_wb,
    input  logic       reg_write_ex,
    input  logic       reg_write_mem,
    input  logic       reg_write_wb,
    input  logic       mem_read_ex,
    input  logic       branch_taken_ex,
    input  logic       dmem_busy,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       ex_mem_stall,
    output logic       id_ex_bubble,
    output logic       if_id_flush,
    output logic [1:0] fwd_sel_rs1,
    output logic [1:0] fwd_sel_rs2,
    output logic [1:0] state,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    localparam int                WAIT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC);

    // Reject configurations that cannot count anything.
    if (TIMEOUT_CYC < 1 || CNT_W < 1) begin : g_param_check
        $error("pipeline_hazard_controller: TIMEOUT_CYC and CNT_W must be >= 1");
    end

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic       load_use;
    logic       mem_stall;
    logic       do_flush;
    logic       do_ld_stall;
    logic [1:0] fwd_rs1_raw;
    logic [1:0] fwd_rs2_raw;

    forward_select_unit u_fwd_rs1 (
        .src_used      (rs1_used_id),
        .src_addr      (rs1_addr_id),
        .reg_write_mem (reg_write_mem),
        .rd_addr_mem   (rd_addr_mem),
        .reg_write_wb  (reg_write_wb),
        .rd_addr_wb    (rd_addr_wb),
        .fwd_sel       (fwd_rs1_raw)
    );

    forward_select_unit u_fwd_rs2 (
        .src_used      (rs2_used_id),
        .src_addr      (rs2_addr_id),
        .reg_write_mem (reg_write_mem),
        .rd_addr_mem   (rd_addr_mem),
        .reg_write_wb  (reg_write_wb),
        .rd_addr_wb    (rd_addr_wb),
        .fwd_sel       (fwd_rs2_raw)
    );

    // A load in EX feeding any used source in ID cannot be forwarded in time.
    assign load_use = mem_read_ex &&
                      (hazard_match(rs1_used_id, rs1_addr_id, reg_write_ex, rd_addr_ex) ||
                       hazard_match(rs2_used_id, rs2_addr_id, reg_write_ex, rd_addr_ex));

    // Next-state and hazard action decode; memory wait beats branch beats load-use.
    always_comb begin
        state_d     = state_q;
        mem_stall   = 1'b0;
        do_flush    = 1'b0;
        do_ld_stall = 1'b0;
        if (dmem_busy) begin
            mem_stall = 1'b1;
            state_d   = ST_MEM_WAIT;
        end else begin
            case (state_q)
                // The instruction behind a flush is already a bubble, so
                // hazard detection is held off for this one cycle.
                ST_FLUSH: state_d = ST_RUN;
                // Memory has just completed: the pipeline moves again and
                // sees normal hazard handling, but always resumes in RUN.
                ST_MEM_WAIT: begin
                    state_d = ST_RUN;
                    if (branch_taken_ex) begin
                        do_flush = 1'b1;
                    end else if (load_use) begin
                        do_ld_stall = 1'b1;
                    end
                end
                default: begin  // ST_RUN, ST_LOAD_STALL
                    if (branch_taken_ex) begin
                        do_flush = 1'b1;
                        state_d  = ST_FLUSH;
                    end else if (load_use) begin
                        do_ld_stall = 1'b1;
                        state_d     = ST_LOAD_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    // Count consecutive busy cycles spent in MEM_WAIT; the timeout flag is sticky.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == ST_MEM_WAIT && dmem_busy) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end
        mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_MAX);
    end

    // FSM state, wait counter and timeout flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Control outputs are combinational so the pipeline reacts in the same
    // cycle; they are forced quiet while reset is held low.
    // NOTE: reset gates these outputs directly because they have no flop that
    // the asynchronous reset could clear.
    assign pc_stall     = reset && (mem_stall || do_ld_stall);
    assign if_id_stall  = reset && (mem_stall || do_ld_stall);
    assign id_ex_stall  = reset && mem_stall;
    assign ex_mem_stall = reset && mem_stall;
    assign id_ex_bubble = reset && (do_flush || do_ld_stall);
    assign if_id_flush  = reset && do_flush;
    assign fwd_sel_rs1  = reset ? fwd_rs1_raw : FWD_RF;
    assign fwd_sel_rs2  = reset ? fwd_rs2_raw : FWD_RF;
    assign state        = state_q;
    assign mem_timeout  = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

    // Saturating event counters for stall, flush and memory-wait cycles.
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        if (do_ld_stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (do_flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (state_q == ST_MEM_WAIT && memwait_cnt_q != '1) begin
            memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_pipeline_hazard_controller;

    localparam int TIMEOUT_CYC = 4;
    localparam int CNT_W       = 2;

    localparam logic [5:0] CTL_NONE = 6'b000000;  // {pc,if_id,id_ex,ex_mem stall, bubble, flush}
    localparam logic [5:0] CTL_MEM  = 6'b111100;
    localparam logic [5:0] CTL_LU   = 6'b110010;
    localparam logic [5:0] CTL_BR   = 6'b000011;

    localparam logic [1:0] S_RUN = 2'b00, S_LS = 2'b01, S_MW = 2'b10, S_FL = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_addr_id, rs2_addr_id;
    logic       rs1_used_id, rs2_used_id;
    logic [4:0] rd_addr_ex, rd_addr_mem, rd_addr_wb;
    logic       reg_write_ex, reg_write_mem, reg_write_wb;
    logic       mem_read_ex, branch_taken_ex, dmem_busy;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic       id_ex_bubble, if_id_flush;
    logic [1:0] fwd_sel_rs1, fwd_sel_rs2, state;
    logic       mem_timeout;
    logic [5:0] ctl;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_controller #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rs1_addr_id     (rs1_addr_id),
        .rs2_addr_id     (rs2_addr_id),
        .rs1_used_id     (rs1_used_id),
        .rs2_used_id     (rs2_used_id),
        .rd_addr_ex      (rd_addr_ex),
        .rd_addr_mem     (rd_addr_mem),
        .rd_addr_wb      (rd_addr_wb),
        .reg_write_ex    (reg_write_ex),
        .reg_write_mem   (reg_write_mem),
        .reg_write_wb    (reg_write_wb),
        .mem_read_ex     (mem_read_ex),
        .branch_taken_ex (branch_taken_ex),
        .dmem_busy       (dmem_busy),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .ex_mem_stall    (ex_mem_stall),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .fwd_sel_rs1     (fwd_sel_rs1),
        .fwd_sel_rs2     (fwd_sel_rs2),
        .state           (state),
        .mem_timeout     (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .memwait_cnt     (memwait_cnt)
`endif
    );

    assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble, if_id_flush};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_addr_id = 5'd0; rs2_addr_id = 5'd0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        rd_addr_ex = 5'd0; rd_addr_mem = 5'd0; rd_addr_wb = 5'd0;
        reg_write_ex = 1'b0; reg_write_mem = 1'b0; reg_write_wb = 1'b0;
        mem_read_ex = 1'b0; branch_taken_ex = 1'b0; dmem_busy = 1'b0;
    endtask

    // EX-stage load to x7 read by rs2 in ID.
    task automatic load_use_x7();
        mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_addr_ex = 5'd7;
        rs2_addr_id = 5'd7; rs2_used_id = 1'b1;
    endtask

    // Drive every kind of hazard at once (used while reset is held).
    task automatic all_hazards();
        load_use_x7();
        branch_taken_ex = 1'b1; dmem_busy = 1'b1;
        rd_addr_mem = 5'd5; reg_write_mem = 1'b1; rs1_addr_id = 5'd5; rs1_used_id = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with every hazard driven: outputs must stay quiet.
        reset = 1'b0;
        idle();
        all_hazards();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", 32'(ctl), 32'(CTL_NONE));
        check("rst_state", 32'(state), 32'(S_RUN));
        check("rst_fwd1", 32'(fwd_sel_rs1), 32'(2'b00));
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        idle();
        reset = 1'b1;

        // Forwarding: MEM beats WB, then WB alone, unused source, x0.
        tick();
        rd_addr_mem = 5'd5; reg_write_mem = 1'b1; rd_addr_wb = 5'd5; reg_write_wb = 1'b1;
        rs1_addr_id = 5'd5; rs1_used_id = 1'b1;
        #1 check("fwd_mem_wins", 32'(fwd_sel_rs1), 32'(2'b01));
        reg_write_mem = 1'b0;
        #1 check("fwd_wb", 32'(fwd_sel_rs1), 32'(2'b10));
        rs2_addr_id = 5'd5; rs2_used_id = 1'b0;
        #1 check("fwd_unused", 32'(fwd_sel_rs2), 32'(2'b00));
        rs2_addr_id = 5'd9; rs2_used_id = 1'b1; rd_addr_wb = 5'd9;
        #1 check("fwd_rs2_wb", 32'(fwd_sel_rs2), 32'(2'b10));
        rd_addr_mem = 5'd0; reg_write_mem = 1'b1; rd_addr_wb = 5'd0; rs1_addr_id = 5'd0;
        #1 check("fwd_x0", 32'(fwd_sel_rs1), 32'(2'b00));
        check("fwd_no_ctl", 32'(ctl), 32'(CTL_NONE));

        // Load-use: one stall cycle, RUN -> LOAD_STALL -> RUN.
        tick();
        idle();
        load_use_x7();
        #1 check("lu_ctl", 32'(ctl), 32'(CTL_LU));
        check("lu_state_run", 32'(state), 32'(S_RUN));
        tick();
        idle();
        #1 check("lu_state_ls", 32'(state), 32'(S_LS));
        check("lu_ls_ctl", 32'(ctl), 32'(CTL_NONE));
        tick();
        #1 check("lu_back_run", 32'(state), 32'(S_RUN));
        // Same pattern through x0 never stalls.
        mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_addr_ex = 5'd0; rs2_addr_id = 5'd0; rs2_used_id = 1'b1;
        #1 check("lu_x0_ctl", 32'(ctl), 32'(CTL_NONE));
        tick();
        #1 check("lu_x0_state", 32'(state), 32'(S_RUN));
        // Repeated load-use is stalled again from LOAD_STALL.
        load_use_x7();
        #1 check("lu2_ctl", 32'(ctl), 32'(CTL_LU));
        tick();
        #1 check("lu2_state_ls", 32'(state), 32'(S_LS));
        check("lu2_ctl_again", 32'(ctl), 32'(CTL_LU));
        tick();
        idle();
        #1 check("lu2_state_ls_again", 32'(state), 32'(S_LS));
        tick();
        #1 check("lu2_back_run", 32'(state), 32'(S_RUN));

        // Branch with concurrent load-use: flush wins, then one FLUSH cycle.
        load_use_x7();
        branch_taken_ex = 1'b1;
        #1 check("br_ctl", 32'(ctl), 32'(CTL_BR));
        check("br_state_run", 32'(state), 32'(S_RUN));
        tick();
        #1 check("br_state_flush", 32'(state), 32'(S_FL));
        check("br_suppressed", 32'(ctl), 32'(CTL_NONE));
        tick();
        idle();
        #1 check("br_back_run", 32'(state), 32'(S_RUN));
        check("br_run_ctl", 32'(ctl), 32'(CTL_NONE));

        // Memory busy for 3 cycles during a branch; flush once busy drops.
        tick();
        branch_taken_ex = 1'b1; dmem_busy = 1'b1;
        #1 check("mb_c0_ctl", 32'(ctl), 32'(CTL_MEM));
        check("mb_c0_state", 32'(state), 32'(S_RUN));
        for (int i = 1; i <= 2; i++) begin
            tick();
            check("mb_ctl", 32'(ctl), 32'(CTL_MEM));
            check("mb_state", 32'(state), 32'(S_MW));
        end
        tick();
        dmem_busy = 1'b0;
        #1 check("mb_flush_ctl", 32'(ctl), 32'(CTL_BR));
        check("mb_flush_state", 32'(state), 32'(S_MW));
        tick();
        idle();
        #1 check("mb_back_run", 32'(state), 32'(S_RUN));
        check("mb_no_timeout", 32'(mem_timeout), 32'd0);

        // Busy for 6 cycles with TIMEOUT_CYC=4: flag rises after 4 MEM_WAIT cycles.
        dmem_busy = 1'b1;
        #1 check("to_c0_ctl", 32'(ctl), 32'(CTL_MEM));
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("to_state", 32'(state), 32'(S_MW));
            check("to_ctl", 32'(ctl), 32'(CTL_MEM));
            check("to_flag", 32'(mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
        end
        tick();
        dmem_busy = 1'b0;
        #1 check("to_exit_state", 32'(state), 32'(S_MW));
        check("to_exit_ctl", 32'(ctl), 32'(CTL_NONE));
        tick();
        #1 check("to_run", 32'(state), 32'(S_RUN));
        check("to_sticky", 32'(mem_timeout), 32'd1);

        // Reset during MEM_WAIT abandons the wait and clears everything.
        dmem_busy = 1'b1;
        tick();
        check("rmw_state", 32'(state), 32'(S_MW));
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_stall", 32'(stall_cnt), 32'd3);
        check("cnt_flush", 32'(flush_cnt), 32'd2);
        check("cnt_memwait_sat", 32'(memwait_cnt), 32'd3);
`endif
        all_hazards();
        reset = 1'b0;
        #1 check("rmw_ctl", 32'(ctl), 32'(CTL_NONE));
        check("rmw_state_run", 32'(state), 32'(S_RUN));
        check("rmw_timeout_clr", 32'(mem_timeout), 32'd0);
        check("rmw_fwd1", 32'(fwd_sel_rs1), 32'(2'b00));
`ifdef HAZARD_PERF_CNT_EN
        check("rmw_cnt_stall", 32'(stall_cnt), 32'd0);
        check("rmw_cnt_flush", 32'(flush_cnt), 32'd0);
        check("rmw_cnt_memwait", 32'(memwait_cnt), 32'd0);
`endif
        idle();
        reset = 1'b1;
        tick();
        check("rmw_after_state", 32'(state), 32'(S_RUN));
        check("rmw_after_ctl", 32'(ctl), 32'(CTL_NONE));

        // Reset during LOAD_STALL leaves no residual stall.
        load_use_x7();
        #1 check("rls_ctl", 32'(ctl), 32'(CTL_LU));
        tick();
        idle();
        #1 check("rls_state", 32'(state), 32'(S_LS));
        load_use_x7();
        reset = 1'b0;
        #1 check("rls_rst_state", 32'(state), 32'(S_RUN));
        check("rls_rst_ctl", 32'(ctl), 32'(CTL_NONE));
        idle();
        reset = 1'b1;
        tick();
        check("rls_after_state", 32'(state), 32'(S_RUN));
        check("rls_after_ctl", 32'(ctl), 32'(CTL_NONE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
